rat_ckpt: RTL

Checkpointed, parametrised register alias table for the out-of-order rename stage. It maps architectural source/destination registers to physical registers for N rename lanes per cycle, with in-group dependency bypass, and returns the displaced mapping for each renamed destination so the ROB can free it at commit. It holds up to NUM_CKPT branch snapshots in a circular buffer, giving single-cycle mispredict recovery without waiting for the RRF. A full flush from the RRF copy is kept for exceptions.

---
 rtl/rat_ckpt.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rat_ckpt.sv
// Register alias table for the rename stage: N-lane lookup with in-group bypass,
// circular branch-snapshot buffer for single-cycle mispredict recovery, RRF flush.
module rat_ckpt #(
    parameter int unsigned PROCESSOR_WIDTH = 2,
    parameter int unsigned ARCH_REGS       = 32,
    parameter int unsigned PHYS_REGS       = 64,
    parameter int unsigned NUM_CKPT        = 4,
    localparam int unsigned ARCH_WIDTH = $clog2(ARCH_REGS),
    localparam int unsigned PHYS_WIDTH = $clog2(PHYS_REGS),
    localparam int unsigned CKPT_WIDTH = $clog2(NUM_CKPT),
    localparam int unsigned LANE_WIDTH = (PROCESSOR_WIDTH > 1) ? $clog2(PROCESSOR_WIDTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ARCH_WIDTH-1:0]      i_arch_src1    [PROCESSOR_WIDTH],
    input  logic [ARCH_WIDTH-1:0]      i_arch_src2    [PROCESSOR_WIDTH],
    input  logic [PROCESSOR_WIDTH-1:0] i_rename_en,
    input  logic [ARCH_WIDTH-1:0]      i_arch_dst     [PROCESSOR_WIDTH],
    input  logic [PHYS_WIDTH-1:0]      i_new_phys_dst [PROCESSOR_WIDTH],
    input  logic                       i_ckpt_alloc,
    input  logic [LANE_WIDTH-1:0]      i_ckpt_lane,
    input  logic                       i_restore_en,
    input  logic [CKPT_WIDTH-1:0]      i_restore_id,
    input  logic                       i_release_en,
    input  logic                       i_full_flush,
    input  logic [PHYS_WIDTH-1:0]      i_rrf_copy     [ARCH_REGS],
    output logic [PHYS_WIDTH-1:0]      o_phys_src1    [PROCESSOR_WIDTH],
    output logic [PHYS_WIDTH-1:0]      o_phys_src2    [PROCESSOR_WIDTH],
    output logic [PHYS_WIDTH-1:0]      o_old_phys_dst [PROCESSOR_WIDTH],
    output logic [CKPT_WIDTH-1:0]      o_ckpt_id,
    output logic                       o_ckpt_avail,
    output logic [CKPT_WIDTH:0]        o_ckpt_count
);

    logic [PHYS_WIDTH-1:0] r_table [ARCH_REGS];
    logic [PHYS_WIDTH-1:0] r_slot  [NUM_CKPT][ARCH_REGS];
    logic [CKPT_WIDTH-1:0] r_head;
    logic [CKPT_WIDTH-1:0] r_tail;
    logic [CKPT_WIDTH:0]   r_count;

    logic [PHYS_WIDTH-1:0] w_next_table [ARCH_REGS];
    logic [PHYS_WIDTH-1:0] w_snap_table [ARCH_REGS];
    logic                  w_avail;
    logic                  w_alloc_ok;
    logic                  w_rel_ok;
    logic [CKPT_WIDTH-1:0] w_restore_dist;

    // Lookups: table value, overridden by the youngest older lane writing the same register
    always_comb begin
        for (int i = 0; i < int'(PROCESSOR_WIDTH); i++) begin
            o_phys_src1[i]    = r_table[i_arch_src1[i]];
            o_phys_src2[i]    = r_table[i_arch_src2[i]];
            o_old_phys_dst[i] = r_table[i_arch_dst[i]];
            for (int j = 0; j < i; j++) begin
                if (i_rename_en[j] && (i_arch_dst[j] != '0)) begin
                    if (i_arch_dst[j] == i_arch_src1[i]) o_phys_src1[i]    = i_new_phys_dst[j];
                    if (i_arch_dst[j] == i_arch_src2[i]) o_phys_src2[i]    = i_new_phys_dst[j];
                    if (i_arch_dst[j] == i_arch_dst[i])  o_old_phys_dst[i] = i_new_phys_dst[j];
                end
            end
            if (i_arch_src1[i] == '0) o_phys_src1[i]    = '0;
            if (i_arch_src2[i] == '0) o_phys_src2[i]    = '0;
            if (i_arch_dst[i] == '0)  o_old_phys_dst[i] = '0;
        end
    end

    // Post-group table and the snapshot image (lanes up to the branch lane only)
    always_comb begin
        w_next_table = r_table;
        w_snap_table = r_table;
        for (int i = 0; i < int'(PROCESSOR_WIDTH); i++) begin
            if (i_rename_en[i] && (i_arch_dst[i] != '0)) begin
                w_next_table[i_arch_dst[i]] = i_new_phys_dst[i];
                if (LANE_WIDTH'(i) <= i_ckpt_lane) w_snap_table[i_arch_dst[i]] = i_new_phys_dst[i];
            end
        end
    end

    assign w_avail        = r_count < (CKPT_WIDTH+1)'(NUM_CKPT);
    assign w_alloc_ok     = i_ckpt_alloc && w_avail && !i_full_flush && !i_restore_en;
    assign w_rel_ok       = i_release_en && (r_count != '0);
    assign w_restore_dist = i_restore_id - r_head;

    assign o_ckpt_id    = r_tail;
    assign o_ckpt_avail = w_avail;
    assign o_ckpt_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) r_table[i] <= PHYS_WIDTH'(i);
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_full_flush) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) r_table[i] <= (i == 0) ? '0 : i_rrf_copy[i];
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_restore_en) begin
            // The restored slot is freed too: live snapshots are only those older than it
            r_table <= r_slot[i_restore_id];
            r_tail  <= i_restore_id;
            if (w_rel_ok && (w_restore_dist != '0)) begin
                r_head  <= r_head + CKPT_WIDTH'(1);
                r_count <= (CKPT_WIDTH+1)'(w_restore_dist) - (CKPT_WIDTH+1)'(1);
            end else begin
                r_count <= (CKPT_WIDTH+1)'(w_restore_dist);
            end
        end else begin
            r_table <= w_next_table;
            if (w_alloc_ok) r_tail <= r_tail + CKPT_WIDTH'(1);
            if (w_rel_ok)   r_head <= r_head + CKPT_WIDTH'(1);
            r_count <= r_count + (CKPT_WIDTH+1)'(w_alloc_ok) - (CKPT_WIDTH+1)'(w_rel_ok);
        end
    end

    // Snapshot storage needs no reset: only slots counted as live are ever restored
    always_ff @(posedge clk) begin
        if (w_alloc_ok) r_slot[r_tail] <= w_snap_table;
    end

endmodule
